// File: rtl/multi_ultrasonic_range_finder.sv
// rtl/multi_ultrasonic_range_finder.sv - round-robin multi-channel ultrasonic ranger; optional velocity output under URF_VELOCITY_EN
module multi_ultrasonic_range_finder #(
    parameter int NUM_CH          = 2,
    parameter int RANGE_W         = 10,
    parameter int SLOT_US         = 40000,
    parameter int TRIG_US         = 10,
    parameter int RISE_TIMEOUT_US = 1000,
    parameter int MAX_ECHO_US     = 23258,
    parameter int RECIP           = 1130,
    parameter int VEL_K           = 3200,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      us_clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         urf_echo_in,
    output logic [NUM_CH-1:0]         urf_trigger_out,
    output logic [NUM_CH*RANGE_W-1:0] urf_range,
    output logic [NUM_CH-1:0]         urf_range_valid,
    output logic [NUM_CH-1:0]         urf_error,
    output logic [CH_W-1:0]           urf_ch_sel,
    output logic                      active_signal,
    output logic [NUM_CH*16-1:0]      z_linear_velocity
);

    // The slot counter is the widest timer; echo and rise timers reuse its width.
    localparam int               CNT_W     = $clog2(SLOT_US);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_US - 1);
    localparam logic [CNT_W-1:0] TRIG_END  = CNT_W'(TRIG_US);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(MAX_ECHO_US);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [15:0]      RANGE_SAT = 16'((1 << RANGE_W) - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_CALC = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [NUM_CH-1:0]         sync1_q, sync2_q, echo_prev_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CH_W-1:0]           ch_sel_q;
    logic [2:0]                state_q, state_d;
    logic [CNT_W-1:0]          hcnt_q, hcnt_d;
    logic                      err_q, err_d;
    logic [NUM_CH-1:0]         trig_q;
    logic [NUM_CH*RANGE_W-1:0] range_q;
    logic [NUM_CH-1:0]         valid_q, error_q;
    logic                      echo_sel, rise_w, fall_w, commit_w;
    logic [15:0]               rng_full_w;
    logic [RANGE_W-1:0]        range_w;

    // All channels are synchronized continuously so switching ch_sel never fabricates an edge.
    assign echo_sel = sync2_q[ch_sel_q];
    assign rise_w   = echo_sel & ~echo_prev_q[ch_sel_q];
    assign fall_w   = ~echo_sel & echo_prev_q[ch_sel_q];

    assign rng_full_w = 16'((32'(hcnt_q) * 32'(RECIP)) >> 16);
    assign range_w    = (rng_full_w > RANGE_SAT) ? RANGE_SAT[RANGE_W-1:0] : rng_full_w[RANGE_W-1:0];

    // Any entry into DONE (result from CALC or an abort) is the single commit point of the slot.
    assign commit_w = (state_d == S_DONE) && (state_q != S_DONE);

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            echo_prev_q <= '0;
        end else begin
            sync1_q     <= urf_echo_in;
            sync2_q     <= sync1_q;
            echo_prev_q <= sync2_q;
        end
    end

    // Slot counter; the owning channel advances round-robin on every wrap.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            ch_sel_q <= '0;
        end else if (cnt_q == SLOT_LAST) begin
            cnt_q    <= '0;
            ch_sel_q <= (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + CH_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Per-slot measurement sequence; hcnt doubles as rise timeout timer and echo width counter.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (cnt_q == '0) begin
                state_d = S_TRIG;
                hcnt_d  = '0;
                err_d   = echo_sel;
            end
            S_TRIG: if (cnt_q == TRIG_END) begin
                state_d = S_WAIT;
                hcnt_d  = '0;
            end
            S_WAIT: if (rise_w) begin
                state_d = S_MEAS;
                hcnt_d  = CNT_W'(1);
            end else if (hcnt_q == RISE_LAST) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
            S_MEAS: if (fall_w) begin
                state_d = S_CALC;
            end else if (hcnt_q == ECHO_MAX) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
            S_CALC: state_d = S_DONE;
            S_DONE: if (cnt_q == SLOT_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and trigger pin, which is high exactly while the FSM sits in TRIG.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            err_q   <= 1'b0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            err_q   <= err_d;
            trig_q  <= '0;
            if (state_d == S_TRIG) trig_q[ch_sel_q] <= 1'b1;
        end
    end

    // Result registers: a good measurement updates range and strobes valid, a failed one only flags error.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            range_q <= '0;
            valid_q <= '0;
            error_q <= '0;
        end else begin
            valid_q <= '0;
            if (commit_w) begin
                if (err_d) begin
                    error_q[ch_sel_q] <= 1'b1;
                end else begin
                    error_q[ch_sel_q] <= 1'b0;
                    valid_q[ch_sel_q] <= 1'b1;
                    range_q[int'(ch_sel_q)*RANGE_W +: RANGE_W] <= range_w;
                end
            end
        end
    end

`ifdef URF_VELOCITY_EN
    localparam logic signed [47:0] VEL_K_S = 48'(VEL_K);

    logic [NUM_CH*16-1:0] vel_q;
    logic [NUM_CH-1:0]    have_prev_q;
    logic signed [16:0]   delta_w;
    logic signed [47:0]   vprod_w, vshift_w;
    logic signed [15:0]   vsat_w;

    // Velocity from the change between the committed range and the one being committed.
    always_comb begin
        delta_w  = $signed(17'(range_w)) - $signed(17'(range_q[int'(ch_sel_q)*RANGE_W +: RANGE_W]));
        vprod_w  = $signed({{31{delta_w[16]}}, delta_w}) * VEL_K_S;
        vshift_w = vprod_w >>> 8;
        if (vshift_w > 48'sd32767) begin
            vsat_w = 16'sh7fff;
        end else if (vshift_w < -48'sd32768) begin
            vsat_w = 16'sh8000;
        end else begin
            vsat_w = vshift_w[15:0];
        end
    end

    // Velocity registers update alongside range_valid; the first good commit has no history and yields 0.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            vel_q       <= '0;
            have_prev_q <= '0;
        end else if (commit_w && !err_d) begin
            have_prev_q[ch_sel_q]             <= 1'b1;
            vel_q[int'(ch_sel_q)*16 +: 16]    <= have_prev_q[ch_sel_q] ? vsat_w : 16'sd0;
        end
    end

    assign z_linear_velocity = vel_q;
`else
    assign z_linear_velocity = '0;
`endif

    assign urf_trigger_out = trig_q;
    assign urf_range       = range_q;
    assign urf_range_valid = valid_q;
    assign urf_error       = error_q;
    assign urf_ch_sel      = ch_sel_q;
    assign active_signal   = (state_q == S_TRIG) || (state_q == S_WAIT) ||
                             (state_q == S_MEAS) || (state_q == S_CALC);

endmodule

// File: tb/tb_multi_ultrasonic_range_finder.sv
// tb/tb_multi_ultrasonic_range_finder.sv - self-checking bench for multi_ultrasonic_range_finder
module tb_multi_ultrasonic_range_finder;

    localparam int NCH   = 3;
    localparam int RW    = 4;
    localparam int SLOT  = 1400;
    localparam int TRIG  = 10;
    localparam int RISE  = 300;
    localparam int MAXE  = 1000;
    localparam int VK    = 3200;

    logic              us_clk = 1'b0;
    logic              reset  = 1'b1;
    logic [NCH-1:0]    echo   = '0;
    logic [NCH-1:0]    urf_trigger_out;
    logic [NCH*RW-1:0] urf_range;
    logic [NCH-1:0]    urf_range_valid;
    logic [NCH-1:0]    urf_error;
    logic [1:0]        urf_ch_sel;
    logic              active_signal;
    logic [NCH*16-1:0] z_linear_velocity;

    int checks   = 0;
    int failures = 0;
    int vcnt[NCH]   = '{default: 0};
    int mrange[NCH] = '{default: 0};
    int merr[NCH]   = '{default: 0};
    int mhave[NCH]  = '{default: 0};
    int mvel[NCH]   = '{default: 0};

    typedef struct {
        int ch;
        int delay;
        int width;
        int stuck;
        int noise;
        int exp_valid;
        int exp_err;
        int exp_range;
    } vec_t;
    vec_t vecs[10];

    multi_ultrasonic_range_finder #(
        .NUM_CH(NCH), .RANGE_W(RW), .SLOT_US(SLOT), .TRIG_US(TRIG),
        .RISE_TIMEOUT_US(RISE), .MAX_ECHO_US(MAXE), .RECIP(1130), .VEL_K(VK)
    ) dut (
        .us_clk(us_clk), .reset(reset), .urf_echo_in(echo),
        .urf_trigger_out(urf_trigger_out), .urf_range(urf_range),
        .urf_range_valid(urf_range_valid), .urf_error(urf_error),
        .urf_ch_sel(urf_ch_sel), .active_signal(active_signal),
        .z_linear_velocity(z_linear_velocity)
    );

    always #5 us_clk = ~us_clk;

    always @(negedge us_clk) begin
        for (int i = 0; i < NCH; i++) if (urf_range_valid[i]) vcnt[i] <= vcnt[i] + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int rng_of(input int c);
        return int'(urf_range[c*RW +: RW]);
    endfunction

    function automatic int vel_of(input int c);
        return int'($signed(z_linear_velocity[c*16 +: 16]));
    endfunction

    task automatic model_commit(input int c, input int ok, input int rng);
`ifdef URF_VELOCITY_EN
        int t;
        if (ok != 0) begin
            if (mhave[c] != 0) begin
                t = ((rng - mrange[c]) * VK) >>> 8;
                if (t > 32767) t = 32767;
                if (t < -32768) t = -32768;
                mvel[c] = t;
            end else begin
                mvel[c] = 0;
            end
            mhave[c] = 1;
        end
`endif
        mrange[c] = rng;
        merr[c]   = (ok != 0) ? 0 : 1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_trig"},  int'(urf_trigger_out), 0);
        chk({tag, "_range"}, int'(urf_range), 0);
        chk({tag, "_valid"}, int'(urf_range_valid), 0);
        chk({tag, "_error"}, int'(urf_error), 0);
        chk({tag, "_chsel"}, int'(urf_ch_sel), 0);
        chk({tag, "_active"}, int'(active_signal), 0);
        chk({tag, "_vel"},   int'(z_linear_velocity != '0), 0);
    endtask

    task automatic release_and_check(input string tag);
        int n;
        @(negedge us_clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge us_clk);
            n++;
        end while (urf_trigger_out == '0 && n < 10);
        chk({tag, "_first_trig_delay"}, n, 1);
        chk({tag, "_first_trig_ch0"}, int'(urf_trigger_out), 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int base[NCH];
        for (int i = 0; i < NCH; i++) base[i] = vcnt[i];
        if (v.stuck != 0) echo[v.ch] = 1'b1;
        n = 0;
        while (!urf_trigger_out[v.ch] && n < 4*SLOT) begin
            @(negedge us_clk);
            n++;
        end
        chk($sformatf("v%0d_trig_seen", idx), int'(urf_trigger_out[v.ch]), 1);
        chk($sformatf("v%0d_chsel", idx), int'(urf_ch_sel), v.ch);
        n = 0;
        while (urf_trigger_out[v.ch] && n < 50) begin
            @(negedge us_clk);
            n++;
        end
        if (v.width > 0 && v.stuck == 0) begin
            repeat (v.delay) @(negedge us_clk);
            echo = NCH'((1 << v.ch) | v.noise);
            repeat (v.width) @(negedge us_clk);
            echo = '0;
        end
        n = 0;
        while (active_signal && n < 2*SLOT) begin
            @(negedge us_clk);
            n++;
        end
        chk($sformatf("v%0d_slot_done", idx), int'(active_signal), 0);
        if (v.stuck != 0) echo = '0;
        repeat (2) @(negedge us_clk);
        model_commit(v.ch, v.exp_valid, v.exp_range);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("v%0d_valid_ch%0d", idx, i), vcnt[i] - base[i], (i == v.ch) ? v.exp_valid : 0);
            chk($sformatf("v%0d_error_ch%0d", idx, i), int'(urf_error[i]), merr[i]);
            chk($sformatf("v%0d_range_ch%0d", idx, i), rng_of(i), mrange[i]);
            chk($sformatf("v%0d_vel_ch%0d", idx, i), vel_of(i), mvel[i]);
        end
        chk($sformatf("v%0d_err_table", idx), int'(urf_error[v.ch]), v.exp_err);
    endtask

    initial begin
        int n;
        int w;
        //          ch  dly  width stuck noise valid err range
        vecs[0] = '{0,  20,  580,  0,    6,    1,    0,  10};
        vecs[1] = '{1,  20,  58,   0,    5,    1,    0,  1};
        vecs[2] = '{2,  50,  1000, 0,    3,    1,    0,  15};
        vecs[3] = '{0,  20,  1001, 0,    0,    0,    1,  10};
        vecs[4] = '{1,  0,   0,    0,    0,    0,    1,  1};
        vecs[5] = '{2,  0,   0,    1,    0,    0,    1,  15};
        vecs[6] = '{0,  30,  812,  0,    0,    1,    0,  14};
        vecs[7] = '{1,  30,  928,  0,    0,    1,    0,  15};
        vecs[8] = '{2,  30,  116,  0,    0,    1,    0,  2};
        vecs[9] = '{0,  20,  580,  0,    0,    1,    0,  10};

        repeat (3) @(negedge us_clk);
        check_reset_state("rst0");
        release_and_check("rst0");

        // Round-robin: consecutive slot starts are SLOT cycles apart, on ch1, ch2, ch0.
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            do begin
                @(negedge us_clk);
                n++;
            end while (urf_trigger_out != '0 && n < 2000);
            do begin
                @(negedge us_clk);
                n++;
            end while (urf_trigger_out == '0 && n < 3000);
            chk($sformatf("rr%0d_period", k), n, SLOT);
            chk($sformatf("rr%0d_trig", k), int'(urf_trigger_out), 1 << (k % 3));
        end
        chk("rr_timeouts_error", int'(urf_error), 7);
        chk("rr_valid_none", vcnt[0] + vcnt[1] + vcnt[2], 0);
        for (int i = 0; i < NCH; i++) merr[i] = 1;

        w = 0;
        while (urf_trigger_out[0] && w < 50) begin
            w++;
            @(negedge us_clk);
        end
        chk("trig_width", w, TRIG);
        n = 0;
        while (active_signal && n < 1000) begin
            @(negedge us_clk);
            n++;
        end
        chk("rise_timeout_cycles", n, RISE);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Latency from the echo pin falling to the valid strobe.
        n = 0;
        while (!urf_trigger_out[0] && n < 4*SLOT) begin
            @(negedge us_clk);
            n++;
        end
        while (urf_trigger_out[0] && n < 5*SLOT) begin
            @(negedge us_clk);
            n++;
        end
        repeat (20) @(negedge us_clk);
        echo[0] = 1'b1;
        repeat (58) @(negedge us_clk);
        echo[0] = 1'b0;
        n = 0;
        while (!urf_range_valid[0] && n < 20) begin
            @(negedge us_clk);
            n++;
        end
        model_commit(0, 1, 1);
        chk("lat_cycles", n, 4);
        chk("lat_range", rng_of(0), 1);
        chk("lat_vel", vel_of(0), mvel[0]);

        // Reset in the middle of a ch1 measurement.
        n = 0;
        while (!urf_trigger_out[1] && n < 4*SLOT) begin
            @(negedge us_clk);
            n++;
        end
        while (urf_trigger_out[1] && n < 5*SLOT) begin
            @(negedge us_clk);
            n++;
        end
        repeat (20) @(negedge us_clk);
        echo[1] = 1'b1;
        repeat (100) @(negedge us_clk);
        chk("mid_meas_active", int'(active_signal), 1);
        chk("mid_meas_range_nonzero", int'(urf_range != '0), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst1");
        echo = '0;
        for (int i = 0; i < NCH; i++) begin
            mrange[i] = 0;
            merr[i]   = 0;
            mhave[i]  = 0;
            mvel[i]   = 0;
        end
        release_and_check("rst1");
        run_vec(9, vecs[9]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
